multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core_pkg.sv | 22 ++
 rtl/core_regfile.sv | 46 ++++
 rtl/multicycle_core.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_core_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// multicycle_core_pkg : opcodes and FSM states for multicycle_core
// Revision 1.0
// ------------------------------------------------------------------
package multicycle_core_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/core_regfile.sv
`default_nettype none
// ------------------------------------------------------------------
// core_regfile : 2 async read ports, 1 sync write port, async reset
// Revision 1.0
// ------------------------------------------------------------------
module core_regfile
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [1:0]        rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [1:0]        w_addr,
  input  logic [DATA_W-1:0] w_data
);

  // Index bits above the register count are dropped (index modulo NREG).
  localparam int AW = (NREG > 2) ? 2 : 1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[w_addr[AW-1:0]] = w_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_addr[AW-1:0]];
  assign rb_data = regs_q[rb_addr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/multicycle_core.sv
`default_nettype none
// ------------------------------------------------------------------
// multicycle_core : FETCH/DECODE/EXEC/MEM/WB core, 8-bit instructions
// Revision 1.0
// ------------------------------------------------------------------
module multicycle_core #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              wb_valid,
  output logic [1:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              retire
);
  import multicycle_core_pkg::*;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [1:0]        wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] rs_data, rt_data;

  logic [1:0]        op;
  logic [DATA_W-1:0] imm_data;
  logic [PC_W-1:0]   imm_pc, pc_inc;
  logic              iack, dack;

  assign op       = instr_q[7:6];
  assign imm_data = {{(DATA_W-2){instr_q[1]}}, instr_q[1:0]};
  assign imm_pc   = {{(PC_W-2){instr_q[1]}}, instr_q[1:0]};
  assign pc_inc   = pc_q + PC_W'(1);
  // Acks only count while our own request is up.
  assign iack     = imem_ack & imem_req_q;
  assign dack     = dmem_ack & dmem_req_q;

  core_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ra_addr (instr_q[5:4]),
    .ra_data (rs_data),
    .rb_addr (instr_q[3:2]),
    .rb_data (rt_data),
    .we      (wb_valid_q),
    .w_addr  (wb_reg_q),
    .w_data  (wb_data_q)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    a_d          = a_q;
    b_d          = b_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;
    retire       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_d = 1'b1;
        if (iack) begin
          instr_d    = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = rs_data;
        b_d     = rt_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op)
          OP_ADD: begin
            wb_reg_d   = instr_q[1:0];
            wb_data_d  = a_q + b_q;
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end
          OP_LW, OP_SW: begin
            dmem_req_d   = 1'b1;
            dmem_we_d    = (op == OP_SW);
            dmem_addr_d  = a_q + imm_data;
            dmem_wdata_d = b_q;
            state_d      = ST_MEM;
          end
          default: begin
            retire     = 1'b1;
            pc_d       = (a_q == b_q) ? pc_inc + imm_pc : pc_inc;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        if (dack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (op == OP_SW) begin
            retire     = 1'b1;
            pc_d       = pc_inc;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            wb_reg_d   = instr_q[3:2];
            wb_data_d  = dmem_rdata;
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end
        end
      end
      ST_WB: begin
        retire     = 1'b1;
        pc_d       = pc_inc;
        imem_req_d = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_reg_q     <= wb_reg_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_multicycle_core : directed + random checks against an ISA model
// Revision 1.0
// ------------------------------------------------------------------
module tb_multicycle_core;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       imem_req, imem_ack;
  logic [7:0] imem_addr, imem_rdata;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0] pc;
  logic       wb_valid, retire;
  logic [1:0] wb_reg;
  logic [7:0] wb_data;

  logic       iack_r = 1'b0, dack_r = 1'b0, dack_pulse = 1'b0;
  int         iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  logic [7:0] imem [256];
  logic [7:0] env_mem [256];

  logic [7:0] model_mem [256];
  logic [7:0] m_regs [4];
  logic [7:0] m_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_ack = iack_r;
  assign dmem_ack = dack_r | dack_pulse;

  multicycle_core u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .retire(retire)
  );

  // Wide-datapath instance running a fixed program with zero-wait memories.
  logic        imem_req16, dmem_req16, dmem_we16, wb_valid16, retire16;
  logic [7:0]  imem_addr16, imem_rdata16, pc16;
  logic [15:0] dmem_addr16, dmem_wdata16, dmem_rdata16, wb_data16;
  logic [1:0]  wb_reg16;
  logic [15:0] cap16 = '0;
  logic        cap16_seen = 1'b0;

  assign imem_rdata16 = (imem_addr16 == 8'd0) ? 8'h45 :   // LW  R1,[R0+1]
                        (imem_addr16 == 8'd1) ? 8'h4B :   // LW  R2,[R0-1]
                        (imem_addr16 == 8'd2) ? 8'h1B :   // ADD R3,R1,R2
                                                8'hC3;    // BEQ R0,R0,-1 (spin)
  assign dmem_rdata16 = (dmem_addr16 == 16'h0001) ? 16'h00FF :
                        (dmem_addr16 == 16'hFFFF) ? 16'h0002 : 16'h0000;

  multicycle_core #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_ack(imem_req16), .imem_rdata(imem_rdata16),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
    .dmem_ack(dmem_req16), .dmem_rdata(dmem_rdata16), .pc(pc16),
    .wb_valid(wb_valid16), .wb_reg(wb_reg16), .wb_data(wb_data16), .retire(retire16)
  );

  always @(negedge clk) begin
    if (wb_valid16 && wb_reg16 == 2'd3) begin
      cap16      = wb_data16;
      cap16_seen = 1'b1;
    end
  end

  // Memory responders: ack after iwait/dwait cycles of request.
  always @(negedge clk) begin
    if (imem_req) begin
      if (icnt >= iwait) begin
        iack_r     = 1'b1;
        imem_rdata = imem[imem_addr];
      end else begin
        iack_r = 1'b0;
        icnt++;
      end
    end else begin
      iack_r = 1'b0;
      icnt   = 0;
    end
    if (dmem_req) begin
      if (dcnt >= dwait) begin
        dack_r     = 1'b1;
        dmem_rdata = env_mem[dmem_addr];
        if (dmem_we) env_mem[dmem_addr] = dmem_wdata;
      end else begin
        dack_r = 1'b0;
        dcnt++;
      end
    end else begin
      dack_r = 1'b0;
      dcnt   = 0;
    end
  end

  // Execute one instruction on the DUT and compare against the ISA model.
  task automatic exec(input logic [7:0] ins, input int iw, input int dw);
    logic [1:0] op, rs, rt, rd, exp_wr, got_wr;
    logic [7:0] imm, a, b, ea, exp_pc, exp_wd, got_wd;
    logic       is_mem, exp_wb, got_ret, dm_bad, overlap;
    int         exp_lat, lat, nd, nwb;
    op = ins[7:6]; rs = ins[5:4]; rt = ins[3:2]; rd = ins[1:0];
    imm = {{6{ins[1]}}, ins[1:0]};
    a = m_regs[rs]; b = m_regs[rt]; ea = a + imm;
    is_mem = (op == 2'd1) || (op == 2'd2);
    exp_pc = m_pc + 8'd1; exp_wb = 1'b0; exp_wr = 2'd0; exp_wd = 8'd0;
    case (op)
      2'd0: begin exp_lat = 4 + iw; exp_wb = 1'b1; exp_wr = rd; exp_wd = a + b; end
      2'd1: begin exp_lat = 5 + iw + dw; exp_wb = 1'b1; exp_wr = rt; exp_wd = model_mem[ea]; end
      2'd2: exp_lat = 4 + iw + dw;
      default: begin exp_lat = 3 + iw; if (a == b) exp_pc = m_pc + 8'd1 + imm; end
    endcase
    imem[m_pc] = ins; iwait = iw; dwait = dw;
    lat = 0; nd = 0; nwb = 0; got_ret = 1'b0; dm_bad = 1'b0; overlap = 1'b0;
    got_wr = 2'd0; got_wd = 8'd0;
    for (int c = 1; c <= 64 && !got_ret; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
          errors++;
          $display("FAIL fetch: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, m_pc);
        end
      end
      if (imem_req && dmem_req) overlap = 1'b1;
      if (dmem_req) begin
        nd++;
        if (dmem_addr !== ea || dmem_we !== (op == 2'd2) || (op == 2'd2 && dmem_wdata !== b)) dm_bad = 1'b1;
      end
      if (wb_valid) begin nwb++; got_wr = wb_reg; got_wd = wb_data; end
      if (retire) begin got_ret = 1'b1; lat = c; end
    end
    checks++;
    if (!got_ret || lat != exp_lat) begin
      errors++;
      $display("FAIL latency ins=%h: got %0d (retired=%b), required %0d", ins, lat, got_ret, exp_lat);
    end
    checks++;
    if (nd != (is_mem ? dw + 1 : 0) || dm_bad) begin
      errors++;
      $display("FAIL dmem ins=%h: req cycles %0d bad=%b addr=%h, required cycles %0d addr=%h wdata=%h",
               ins, nd, dm_bad, dmem_addr, is_mem ? dw + 1 : 0, ea, b);
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL req_overlap ins=%h: imem_req and dmem_req both high, required never", ins);
    end
    checks++;
    if (nwb != (exp_wb ? 1 : 0)) begin
      errors++;
      $display("FAIL wb_count ins=%h: got %0d, required %0d", ins, nwb, exp_wb ? 1 : 0);
    end
    if (exp_wb) begin
      checks++;
      if (got_wr !== exp_wr || got_wd !== exp_wd) begin
        errors++;
        $display("FAIL wb ins=%h: reg=%0d data=%h, required reg=%0d data=%h", ins, got_wr, got_wd, exp_wr, exp_wd);
      end
      m_regs[exp_wr] = exp_wd;
    end
    if (op == 2'd2) begin
      checks++;
      if (env_mem[ea] !== b) begin
        errors++;
        $display("FAIL store ins=%h: mem[%h]=%h, required %h", ins, ea, env_mem[ea], b);
      end
      model_mem[ea] = b;
    end
    m_pc = exp_pc;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; #1;
    checks++;
    if ({imem_req, dmem_req, dmem_we, wb_valid, retire} !== 5'b0 || pc !== 8'h00 ||
        dmem_addr !== 8'h00 || dmem_wdata !== 8'h00 || wb_reg !== 2'd0 || wb_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: req=%b/%b we=%b wbv=%b ret=%b pc=%h, required all zero",
               imem_req, dmem_req, dmem_we, wb_valid, retire, pc);
    end
    repeat (2) @(negedge clk);
    #1;
    dack_pulse = 1'b0; iwait = 0; dwait = 0;
    reset_n = 1'b1;
    m_pc = 8'h00;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
  endtask

  task automatic test_add_basic();
    exec(8'h01, 0, 0);                       // ADD R1,R0,R0
  endtask

  task automatic test_sw_delayed();
    exec(8'h48, 0, 0);                       // LW R2,[R0+0] -> 0x5A
    exec(8'h89, 0, 3);                       // SW R2,[R0+1] with 3 wait cycles
  endtask

  task automatic test_lw_neg();
    exec(8'h4F, 0, 0);                       // LW R3,[R0-1] -> 0xC3
  endtask

  task automatic test_branch();
    exec(8'h21, 0, 0);                       // pc4: ADD R1,R2,R0
    exec(8'hC2, 0, 0);                       // pc5: BEQ R0,R0,-2 -> 4
    exec(8'h21, 1, 0);                       // pc4 again
    exec(8'hC5, 0, 0);                       // pc5: BEQ R0,R1,+1 not taken -> 6
    for (int i = 0; i < 7; i++) exec(8'hC2, 0, 0);  // walk pc down to 0xFF
    exec(8'hC5, 0, 0);                       // pc 0xFF not taken -> wraps to 0
    exec(8'h00, 0, 0);                       // fetch from 0
  endtask

  task automatic test_add_overflow();
    exec(8'h65, 0, 0);                       // LW R1,[R2+1] -> 0xFF
    exec(8'h6C, 2, 1);                       // LW R3,[R2+0] -> 0x02
    exec(8'h1D, 0, 0);                       // ADD R1,R1,R3 -> 0x01
  endtask

  task automatic test_reset_mid_mem();
    logic seen;
    int   bad;
    imem[m_pc] = 8'h44;                      // LW R1,[R0+0]
    iwait = 0; dwait = 30; seen = 1'b0; bad = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #1;
      if (dmem_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mem_start: dmem_req=%b, required 1", dmem_req); end
    @(negedge clk); #1;
    reset_n = 1'b0; #1;
    checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h00 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: dreq=%b ireq=%b pc=%h wbv=%b, required 0 0 00 0", dmem_req, imem_req, pc, wb_valid);
    end
    @(negedge clk);
    dack_pulse = 1'b1;
    @(negedge clk); #1;
    dwait = 0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL release_fetch: ireq=%b addr=%h dreq=%b, required 1 00 0", imem_req, imem_addr, dmem_req);
    end
    repeat (3) begin
      @(negedge clk); #1;
      dack_pulse = 1'b0;
      if (wb_valid || dmem_req) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stale_ack: %0d write/access cycles, required 0", bad); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++)
      exec(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_width16();
    checks++;
    if (!cap16_seen || cap16 !== 16'h0101) begin
      errors++;
      $display("FAIL add16: wb_data=%h seen=%b, required 0101", cap16, cap16_seen);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      imem[i]      = 8'h00;
      env_mem[i]   = 8'($urandom);
      model_mem[i] = env_mem[i];
    end
    env_mem[8'h00] = 8'h5A; model_mem[8'h00] = 8'h5A;
    env_mem[8'hFF] = 8'hC3; model_mem[8'hFF] = 8'hC3;
    env_mem[8'h5B] = 8'hFF; model_mem[8'h5B] = 8'hFF;
    env_mem[8'h5A] = 8'h02; model_mem[8'h5A] = 8'h02;
    test_reset();
    test_add_basic();
    test_sw_delayed();
    test_lw_neg();
    test_branch();
    test_add_overflow();
    test_reset_mid_mem();
    test_reset();
    test_random();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
